// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and state encoding for the repeated-subtraction divider
//
// Purpose: state encoding used by div_controlpath and default operand width.
// Contents: state_t (3-bit), DIV_W.
// Build option: DIV_SINGLE_CYCLE_ITER_EN reuses S_CHECK as the merged ITER state.
package div_pkg;

    localparam int DIV_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_SUB   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/div_controlpath.sv
// rtl/div_controlpath.sv - sequencing FSM for the repeated-subtraction divider
//
// Purpose: walks IDLE -> LOAD -> (CHECK <-> SUB)* -> DONE and issues datapath strobes.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               request, honoured in IDLE; holds DONE while high
//   lt                  datapath R < B
//   dz_in               live divisor == 0 (meaningful in LOAD)
//   ldR, ldB            capture dividend / divisor (LOAD)
//   clrQ                clear Q and dz flag (IDLE, LOAD)
//   sub, incQ           R <= R - B, Q <= Q + 1
//   setdz               divide-by-zero detected in LOAD
//   busy, done          status, registered
// Build option: DIV_SINGLE_CYCLE_ITER_EN merges CHECK and SUB into one ITER state
// (encoded as S_CHECK) that subtracts every cycle while R >= B.
module div_controlpath
    import div_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic lt,
    input  logic dz_in,
    output logic ldR,
    output logic ldB,
    output logic clrQ,
    output logic sub,
    output logic incQ,
    output logic setdz,
    output logic busy,
    output logic done
);

    state_t state;
    state_t nxt;

    logic load_r;
    logic clr_r;
    logic sub_r;

    function automatic state_t next_state(input state_t s, input logic st,
                                           input logic l, input logic z);
        state_t n;
        case (s)
            S_IDLE:  n = st ? S_LOAD : S_IDLE;
            S_LOAD:  n = z ? S_DONE : S_CHECK;
`ifdef DIV_SINGLE_CYCLE_ITER_EN
            S_CHECK: n = l ? S_DONE : S_CHECK;
            S_SUB:   n = S_IDLE;          // not reachable in the merged build
`else
            S_CHECK: n = l ? S_DONE : S_SUB;
            S_SUB:   n = S_CHECK;
`endif
            S_DONE:  n = st ? S_DONE : S_IDLE;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    assign nxt = next_state(state, start, lt, dz_in);

    // Status and phase strobes are registered from the next state so they
    // line up with the state register and are all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            load_r <= 1'b0;
            clr_r  <= 1'b0;
            sub_r  <= 1'b0;
        end else begin
            state  <= nxt;
            busy   <= (nxt == S_LOAD) || (nxt == S_CHECK) || (nxt == S_SUB);
            done   <= (nxt == S_DONE);
            load_r <= (nxt == S_LOAD);
            clr_r  <= (nxt == S_IDLE) || (nxt == S_LOAD);
            sub_r  <= (nxt == S_SUB);
        end
    end

    assign ldR   = load_r;
    assign ldB   = load_r;
    assign clrQ  = clr_r;
    // The zero test needs the divisor present during LOAD, so it is qualified live.
    assign setdz = load_r & dz_in;

`ifdef DIV_SINGLE_CYCLE_ITER_EN
    // ITER subtracts in the same cycle it sees R >= B.
    assign sub  = busy & (state == S_CHECK) & ~lt;
`else
    assign sub  = sub_r;
`endif
    assign incQ = sub;

endmodule

// File: rtl/div_repsub.sv
// rtl/div_repsub.sv - sequential unsigned divider by repeated subtraction
//
// Purpose: quotient/remainder of dividend/divisor, one subtraction per iteration,
// result held in DONE until start drops.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                request (IDLE), hold (DONE)
//   dividend, divisor    operands, sampled during LOAD only
//   quotient, remainder  views of Q and R; qualify with done
//   busy                 LOAD/CHECK/SUB
//   done                 DONE
//   div_by_zero          DONE with a zero divisor (Q = all ones, R = dividend)
// Build option: DIV_SINGLE_CYCLE_ITER_EN (see div_controlpath), latency q+3 instead of 2q+3.
module div_repsub
    import div_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    logic [W-1:0] r_q;
    logic [W-1:0] b_q;
    logic [W-1:0] q_q;
    logic         dz_q;

    logic lt;
    logic dz_in;
    logic ldR;
    logic ldB;
    logic clrQ;
    logic sub;
    logic incQ;
    logic setdz;

    assign lt    = (r_q < b_q);
    assign dz_in = (divisor == '0);

    div_controlpath u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .lt    (lt),
        .dz_in (dz_in),
        .ldR   (ldR),
        .ldB   (ldB),
        .clrQ  (clrQ),
        .sub   (sub),
        .incQ  (incQ),
        .setdz (setdz),
        .busy  (busy),
        .done  (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q  <= '0;
            b_q  <= '0;
            q_q  <= '0;
            dz_q <= 1'b0;
        end else begin
            if (ldR)
                r_q <= dividend;
            else if (sub)
                r_q <= r_q - b_q;

            if (ldB)
                b_q <= divisor;

            // setdz only fires in LOAD, where clrQ is also high, so it must win.
            if (setdz)
                q_q <= '1;
            else if (clrQ)
                q_q <= '0;
            else if (incQ)
                q_q <= q_q + {{(W-1){1'b0}}, 1'b1};

            if (clrQ)
                dz_q <= setdz;
        end
    end

    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dz_q & done;

endmodule

// File: tb/tb_div_repsub.sv
// tb/tb_div_repsub.sv - scoreboard testbench for div_repsub
module tb_div_repsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int total = 0;
    int bad = 0;

    typedef struct {
        int q;
        int r;
        int dz;
        int lat;
    } exp_t;

    exp_t sb[$];

    div_repsub #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        if (b == 0) begin
            e.q = (1 << W) - 1;
            e.r = a;
            e.dz = 1;
            e.lat = 2;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dz = 0;
`ifdef DIV_SINGLE_CYCLE_ITER_EN
            e.lat = e.q + 3;
`else
            e.lat = 2 * e.q + 3;
`endif
        end
        return e;
    endfunction

    // Pulse start for one cycle, count edges up to done, then check against the queue head.
    task automatic run(input int a, input int b, input string tag);
        int   edges;
        logic busy_ok;
        exp_t e;
        @(negedge clk);
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        busy_ok = 1'b1;
        while (!done && edges < 2000) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        e = sb.pop_front();
        chk({tag, " done"}, done, 1);
        chk({tag, " latency"}, edges, e.lat);
        chk({tag, " quotient"}, quotient, e.q);
        chk({tag, " remainder"}, remainder, e.r);
        chk({tag, " div_by_zero"}, div_by_zero, e.dz);
        chk({tag, " busy_during_run"}, busy_ok, 1);
        chk({tag, " busy_with_done"}, busy, 0);
    endtask

    initial begin
        int edges;
        #2;
        chk("reset quotient", quotient, 0);
        chk("reset remainder", remainder, 0);
        chk("reset flags", {busy, done, div_by_zero}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle flags", {busy, done, div_by_zero}, 0);

        run(13, 4, "13/4");
        run(3, 7, "3/7");
        run(0, 5, "0/5");
        run(255, 1, "255/1");
        run(200, 0, "200/0");
        run(91, 13, "91/13");

        // Abort mid-operation with an asynchronous reset at edge 10.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        chk("pre-abort busy", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("abort quotient", quotient, 0);
        chk("abort remainder", remainder, 0);
        chk("abort flags", {busy, done, div_by_zero}, 0);
        @(negedge clk);
        rst = 1'b0;
        run(100, 3, "100/3 after abort");

        // Held start keeps DONE; one low/high cycle yields exactly one new run.
        @(negedge clk);
        dividend = 8'd20;
        divisor  = 8'd6;
        start    = 1'b1;
        edges = 0;
        while (!done && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        chk("held reached done", done, 1);
        repeat (4) @(negedge clk);
        chk("held stays done", done, 1);
        chk("held quotient", quotient, 3);
        chk("held remainder", remainder, 2);
        start = 1'b0;
        @(negedge clk);
        chk("release to idle", {busy, done}, 0);
        run(50, 7, "50/7 retrigger");
        repeat (6) @(negedge clk);
        chk("no extra run", {busy, done}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_repsub.md
Name: div_repsub

Overview:
- Sequential unsigned divider using repeated subtraction.
- It is the inverse of the team's repeated-addition multiplier. It uses the same controller/datapath split and the same start/done handshake.
- It computes quotient and remainder of dividend/divisor with one subtraction per iteration, then holds the result until released.
- It is intended as a small arithmetic co-unit beside the multiplier in the same datapath.

Parameters:
- W, 8, operand/result width in bits (W >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled in IDLE and DONE.
- dividend  input  W  numerator; captured in LOAD.
- divisor  input  W  denominator; captured in LOAD.
- quotient  output  W  Q register; valid while done=1.
- remainder  output  W  R register; valid while done=1.
- busy  output  1  high in LOAD, CHECK, SUB.
- done  output  1  high only in DONE (Moore).
- div_by_zero  output  1  high in DONE when the captured divisor was 0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; Q, R, B registers=0; dz flag=0.
  - All outputs 0 while rst is high, independent of clk.
  - rst mid-operation aborts immediately; no partial result is retained.
- States: IDLE, LOAD, CHECK, SUB, DONE, encoded in 3 bits. Unused encodings go to IDLE on the next edge.
- IDLE: clears Q and dz. Moves to LOAD when start=1, else stays in IDLE.
- LOAD:
  - R<=dividend, B<=divisor, Q<=0.
  - If divisor==0: dz<=1, Q<={W{1'b1}}, R<=dividend, next=DONE.
  - Otherwise next=CHECK.
- CHECK: compares R<B (unsigned, W bits). If true, next=DONE; else next=SUB. No register update.
- SUB:
  - R<=R-B. Never underflows because CHECK guarantees R>=B.
  - Q<=Q+1. Cannot overflow, since Q<=dividend<2^W.
  - next=CHECK.
- DONE:
  - done=1; Q and R held.
  - Stays in DONE while start=1. This prevents retrigger from a held start.
  - Goes to IDLE when start=0. A new result needs start to be low for at least one cycle, then high again.
- Latency, counted in rising edges from the edge that samples start=1 in IDLE to the first cycle with done=1:
  - 2q+3, where q is the final quotient.
  - Divide-by-zero: 2.
- Operand timing:
  - dividend and divisor must be stable during the LOAD cycle.
  - Changes in any other state are ignored.
- Outputs:
  - quotient and remainder are direct views of the Q and R registers. They change during the computation; consumers qualify them with done.
  - busy and done are never high together.

Optional Feature:
- Macro: DIV_SINGLE_CYCLE_ITER_EN.
- When defined:
  - CHECK and SUB are merged into one state ITER.
  - Each cycle, if R>=B then R<=R-B and Q<=Q+1 and the state stays in ITER; else next=DONE.
  - Latency becomes q+3; divide-by-zero stays at 2.
- When undefined: two-state iteration as above, latency 2q+3.
- Results are identical in both builds. The Test Plan checks against the latency formula for the build in use.

Decomposition:
- Shared package div_pkg:
  - State encoding constants S_IDLE=0, S_LOAD=1, S_CHECK=2, S_SUB=3, S_DONE=4.
  - Default width constant DIV_W=8.
- Natural sub-module div_controlpath:
  - Inputs: clk, rst, start, lt (R<B), dz_in (divisor==0).
  - Outputs: ldR, ldB, clrQ, sub, incQ, setdz, busy, done.
- div_repsub instantiates div_controlpath and holds the R, B and Q registers, the subtractor and the comparator.

Test Plan:
- 13/4, start pulsed 1 cycle -> done after 9 edges; quotient=3, remainder=1, div_by_zero=0. Single-cycle build: 6 edges.
- 3/7 -> done after 3 edges; quotient=0, remainder=3.
- 0/5 -> quotient=0, remainder=0, 3 edges.
- 255/1 (W=8) -> quotient=255, remainder=0 after 513 edges; busy=1 throughout computation.
- 200/0 -> done after 2 edges; div_by_zero=1, quotient=255, remainder=200.
- Two adjacent cases:
  - Start 100/3, assert rst at edge 10 -> all outputs 0 asynchronously.
  - After release, 100/3 gives quotient=33, remainder=1.
  - start held high through DONE -> stays in DONE. A start low then high gives exactly one new run.
